// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared Dcache types, line geometry and the line-align helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int LINE_W     = 128;
    localparam int LINE_OFF_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } miss_state_t;

    // Works on a 64-bit container so any address width up to 64 can use it.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return {addr[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_miss_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_miss_ctrl
// Description : Dcache miss/refill sequencer with victim writeback and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              victim_dirty_i,
    input  logic [ADDR_W-1:0] victim_addr_i,
    input  logic [LINE_W-1:0] victim_data_i,
    output logic              miss_ready_o,
    output logic              refill_valid_o,
    output logic [ADDR_W-1:0] refill_addr_o,
    output logic [LINE_W-1:0] refill_line_o,
    output logic [31:0]       refill_word_o,
    output logic              err_o,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              wb_req_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o,
    input  logic [LINE_W-1:0] ram_data_i,
    input  logic              ram_ready_i,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
);

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYC - 1);

    miss_state_t       r_state;
    logic [ADDR_W-1:0] r_miss_addr;
    logic [1:0]        r_word_idx;
    logic [ADDR_W-1:0] r_victim_addr;
    logic [LINE_W-1:0] r_victim_data;
    logic [LINE_W-1:0] r_line;
    logic [31:0]       r_refill_word;
    logic [7:0]        r_tmo_cnt;
    logic              r_miss_ready;
    logic              r_refill_valid;
    logic              r_err;
    logic              r_rd_req;
    logic              r_wb_req;

    logic [ADDR_W-1:0] w_miss_line;
    logic [ADDR_W-1:0] w_victim_line;
    logic              w_accept;
    logic              w_wb_issue;

    assign w_miss_line   = ADDR_W'(line_align(64'(miss_addr_i)));
    assign w_victim_line = ADDR_W'(line_align(64'(victim_addr_i)));
    assign w_accept      = (r_state == ST_IDLE) && miss_req_i;
    assign w_wb_issue    = (r_state == ST_WB);

    // Request/pulse outputs are set on the transition into their state so
    // they appear exactly in that state's cycle without decode from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_miss_addr    <= '0;
            r_word_idx     <= '0;
            r_victim_addr  <= '0;
            r_victim_data  <= '0;
            r_line         <= '0;
            r_refill_word  <= '0;
            r_tmo_cnt      <= '0;
            r_miss_ready   <= 1'b1;
            r_refill_valid <= 1'b0;
            r_err          <= 1'b0;
            r_rd_req       <= 1'b0;
            r_wb_req       <= 1'b0;
        end else begin
            r_refill_valid <= 1'b0;
            r_err          <= 1'b0;
            r_rd_req       <= 1'b0;
            r_wb_req       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_miss_addr   <= w_miss_line;
                        r_word_idx    <= miss_addr_i[3:2];
                        r_victim_addr <= w_victim_line;
                        r_victim_data <= victim_data_i;
                        r_miss_ready  <= 1'b0;
                        if (victim_dirty_i) begin
                            r_state  <= ST_WB;
                            r_wb_req <= 1'b1;
                        end else begin
                            r_state  <= ST_RD_REQ;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    r_state  <= ST_RD_REQ;
                    r_rd_req <= 1'b1;
                end
                ST_RD_REQ: begin
                    r_state   <= ST_RD_WAIT;
                    r_tmo_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (ram_ready_i) begin
                        r_line         <= ram_data_i;
                        r_refill_word  <= ram_data_i[{r_word_idx, 5'd0} +: 32];
                        r_state        <= ST_RESP;
                        r_refill_valid <= 1'b1;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_state      <= ST_IDLE;
                        r_err        <= 1'b1;
                        r_miss_ready <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_miss_ready <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_miss_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(32)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_accept),
        .count (miss_cnt_o)
    );

    sat_counter #(.WIDTH(32)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_wb_issue),
        .count (wb_cnt_o)
    );

    assign miss_ready_o   = r_miss_ready;
    assign refill_valid_o = r_refill_valid;
    assign refill_addr_o  = r_miss_addr;
    assign refill_line_o  = r_line;
    assign refill_word_o  = r_refill_word;
    assign err_o          = r_err;
    assign rd_req_o       = r_rd_req;
    assign rd_addr_o      = r_miss_addr;
    assign wb_req_o       = r_wb_req;
    assign wb_addr_o      = r_victim_addr;
    assign wb_data_o      = r_victim_data;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_miss_ctrl
// Description : Directed self-checking bench with RAM model and refill scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_ctrl;
    import dcache_pkg::*;

    logic         clk;
    logic         rst;
    logic         miss_req_i;
    logic [31:0]  miss_addr_i;
    logic         victim_dirty_i;
    logic [31:0]  victim_addr_i;
    logic [127:0] victim_data_i;
    logic         miss_ready_o;
    logic         refill_valid_o;
    logic [31:0]  refill_addr_o;
    logic [127:0] refill_line_o;
    logic [31:0]  refill_word_o;
    logic         err_o;
    logic         rd_req_o;
    logic [31:0]  rd_addr_o;
    logic         wb_req_o;
    logic [31:0]  wb_addr_o;
    logic [127:0] wb_data_o;
    logic [127:0] ram_data;
    logic         model_ready;
    logic         stray_ready;
    logic         ram_ready;
    logic [31:0]  miss_cnt_o;
    logic [31:0]  wb_cnt_o;

    assign ram_ready = model_ready | stray_ready;

    int checks     = 0;
    int failures   = 0;
    int err_pulses = 0;

    typedef struct packed {
        logic [31:0]  addr;
        logic [31:0]  word;
        logic [127:0] line;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mem [logic [31:0]];
    logic         ram_en;

    logic [127:0] line_a;
    logic [127:0] line_b;
    logic [127:0] line_c;
    logic [127:0] vdata;

    dcache_miss_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_req_i     (miss_req_i),
        .miss_addr_i    (miss_addr_i),
        .victim_dirty_i (victim_dirty_i),
        .victim_addr_i  (victim_addr_i),
        .victim_data_i  (victim_data_i),
        .miss_ready_o   (miss_ready_o),
        .refill_valid_o (refill_valid_o),
        .refill_addr_o  (refill_addr_o),
        .refill_line_o  (refill_line_o),
        .refill_word_o  (refill_word_o),
        .err_o          (err_o),
        .rd_req_o       (rd_req_o),
        .rd_addr_o      (rd_addr_o),
        .wb_req_o       (wb_req_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .ram_data_i     (ram_data),
        .ram_ready_i    (ram_ready),
        .miss_cnt_o     (miss_cnt_o),
        .wb_cnt_o       (wb_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_miss(input logic [31:0] addr, input logic dirty,
                              input logic [31:0] vaddr, input logic [127:0] vdat);
        miss_req_i     = 1'b1;
        miss_addr_i    = addr;
        victim_dirty_i = dirty;
        victim_addr_i  = vaddr;
        victim_data_i  = vdat;
    endtask

    // RAM model: answers a read two cycles after rd_req is seen, stores writebacks.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        pend        = 1'b0;
        paddr       = '0;
        model_ready = 1'b0;
        ram_data    = '0;
        forever begin
            @(negedge clk);
            model_ready = 1'b0;
            if (pend && ram_en && !rst) begin
                model_ready = 1'b1;
                ram_data    = mem.exists(paddr) ? mem[paddr] : '0;
            end
            pend = 1'b0;
            if (rd_req_o) begin
                pend  = 1'b1;
                paddr = rd_addr_o;
            end
            if (wb_req_o) mem[wb_addr_o] = wb_data_o;
        end
    end

    // Scoreboard: every refill pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (err_o) err_pulses++;
            if (refill_valid_o) begin
                if (sb.size() == 0) begin
                    chk1("refill_unexpected", refill_valid_o, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk32("sb_addr", refill_addr_o, e.addr);
                    chk32("sb_word", refill_word_o, e.word);
                    chk128("sb_line", refill_line_o, e.line);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_a = {32'hDDDD3333, 32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
        line_b = {32'h44444444, 32'h33333333, 32'h22222222, 32'h1111CAFE};
        line_c = {32'h87654321, 32'h0BADF00D, 32'h12345678, 32'hFEEDFACE};
        vdata  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        mem[32'h120] = line_a;
        mem[32'h010] = line_b;
        mem[32'h200] = line_c;
        ram_en       = 1'b1;
        stray_ready  = 1'b0;
        rst          = 1'b1;
        miss_req_i   = 1'b0;
        miss_addr_i  = '0;
        victim_dirty_i = 1'b0;
        victim_addr_i  = '0;
        victim_data_i  = '0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        chk1("rst_ready", miss_ready_o, 1'b1);
        chk1("rst_rd_req", rd_req_o, 1'b0);
        chk1("rst_wb_req", wb_req_o, 1'b0);
        chk1("rst_refill", refill_valid_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk128("rst_line", refill_line_o, 128'd0);
        chk32("rst_miss_cnt", miss_cnt_o, 32'd0);
        chk32("rst_wb_cnt", wb_cnt_o, 32'd0);

        // Clean miss at 0x128 -> word 2 of line 0x120
        drive_miss(32'h128, 1'b0, 32'h0, 128'd0);
        sb.push_back(exp_t'{32'h120, 32'hCCCC2222, line_a});
        tick(); miss_req_i = 1'b0;
        chk1("clean_rd_req_n1", rd_req_o, 1'b1);
        chk32("clean_rd_addr", rd_addr_o, 32'h120);
        chk1("clean_wb_req_n1", wb_req_o, 1'b0);
        chk1("clean_busy_n1", miss_ready_o, 1'b0);
        chk32("clean_miss_cnt", miss_cnt_o, 32'd1);
        tick();
        chk1("clean_rd_req_n2", rd_req_o, 1'b0);
        chk1("clean_refill_n2", refill_valid_o, 1'b0);
        tick();
        chk1("clean_refill_n3", refill_valid_o, 1'b1);
        chk32("clean_word", refill_word_o, 32'hCCCC2222);
        chk32("clean_refill_addr", refill_addr_o, 32'h120);
        tick();
        chk1("clean_ready_n4", miss_ready_o, 1'b1);
        chk1("clean_refill_n4", refill_valid_o, 1'b0);

        // Dirty miss: victim 0x340 written back, then refill of 0x10
        drive_miss(32'h010, 1'b1, 32'h340, vdata);
        sb.push_back(exp_t'{32'h010, 32'h1111CAFE, line_b});
        tick(); miss_req_i = 1'b0; victim_dirty_i = 1'b0;
        chk1("dirty_wb_req_n1", wb_req_o, 1'b1);
        chk1("dirty_rd_req_n1", rd_req_o, 1'b0);
        chk32("dirty_wb_addr", wb_addr_o, 32'h340);
        chk128("dirty_wb_data", wb_data_o, vdata);
        tick();
        chk1("dirty_rd_req_n2", rd_req_o, 1'b1);
        chk1("dirty_wb_req_n2", wb_req_o, 1'b0);
        chk32("dirty_rd_addr", rd_addr_o, 32'h010);
        chk32("dirty_wb_cnt", wb_cnt_o, 32'd1);
        tick();
        chk1("dirty_refill_n3", refill_valid_o, 1'b0);
        tick();
        chk1("dirty_refill_n4", refill_valid_o, 1'b1);
        tick();
        chk1("dirty_ready_n5", miss_ready_o, 1'b1);

        // Back-to-back readback of the written-back line, word 3
        drive_miss(32'h34C, 1'b0, 32'h0, 128'd0);
        sb.push_back(exp_t'{32'h340, 32'h0F0E0D0C, vdata});
        tick(); miss_req_i = 1'b0;
        chk1("rb_rd_req", rd_req_o, 1'b1);
        chk32("rb_rd_addr", rd_addr_o, 32'h340);
        tick(); tick();
        chk1("rb_refill", refill_valid_o, 1'b1);
        tick();

        // Busy: request held high through a whole miss
        drive_miss(32'h204, 1'b0, 32'h0, 128'd0);
        sb.push_back(exp_t'{32'h200, 32'h12345678, line_c});
        sb.push_back(exp_t'{32'h200, 32'h12345678, line_c});
        tick();
        chk1("busy_rd_req_n1", rd_req_o, 1'b1);
        chk32("busy_cnt_n1", miss_cnt_o, 32'd4);
        tick();
        chk1("busy_rd_req_n2", rd_req_o, 1'b0);
        chk1("busy_ready_n2", miss_ready_o, 1'b0);
        tick();
        chk1("busy_refill_n3", refill_valid_o, 1'b1);
        chk1("busy_ready_n3", miss_ready_o, 1'b0);
        chk32("busy_cnt_n3", miss_cnt_o, 32'd4);
        tick();
        chk1("busy_ready_n4", miss_ready_o, 1'b1);
        tick(); miss_req_i = 1'b0;
        chk1("busy_rd_req_n5", rd_req_o, 1'b1);
        chk32("busy_cnt_n5", miss_cnt_o, 32'd5);
        tick(); tick(); tick();
        chk1("busy_ready_end", miss_ready_o, 1'b1);

        // Timeout: RAM silent, err 4 cycles after rd_req
        ram_en = 1'b0;
        drive_miss(32'h400, 1'b0, 32'h0, 128'd0);
        tick(); miss_req_i = 1'b0;
        chk1("tmo_rd_req", rd_req_o, 1'b1);
        tick(); tick(); tick();
        chk1("tmo_err_early", err_o, 1'b0);
        tick();
        chk1("tmo_err", err_o, 1'b1);
        chk1("tmo_ready_err", miss_ready_o, 1'b1);
        chk1("tmo_no_refill", refill_valid_o, 1'b0);
        tick();
        chk1("tmo_err_drop", err_o, 1'b0);
        chk1("tmo_ready_next", miss_ready_o, 1'b1);
        stray_ready = 1'b1;
        tick(); stray_ready = 1'b0;
        chk1("tmo_late_rd_req", rd_req_o, 1'b0);
        chk1("tmo_late_ready", miss_ready_o, 1'b1);
        tick();
        chk1("tmo_late_refill", refill_valid_o, 1'b0);
        chk32("tmo_miss_cnt", miss_cnt_o, 32'd6);

        // Reset asserted during RD_WAIT
        drive_miss(32'h500, 1'b0, 32'h0, 128'd0);
        tick(); miss_req_i = 1'b0;
        chk1("mid_rd_req", rd_req_o, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("mid_ready", miss_ready_o, 1'b1);
        chk1("mid_rd_req_drop", rd_req_o, 1'b0);
        chk1("mid_wb_req", wb_req_o, 1'b0);
        chk1("mid_refill", refill_valid_o, 1'b0);
        chk1("mid_err", err_o, 1'b0);
        chk32("mid_rd_addr", rd_addr_o, 32'd0);
        chk128("mid_line", refill_line_o, 128'd0);
        chk32("mid_miss_cnt", miss_cnt_o, 32'd0);
        chk32("mid_wb_cnt", wb_cnt_o, 32'd0);
        stray_ready = 1'b1;
        tick(); stray_ready = 1'b0;
        tick();
        chk1("stray_ready_idle", miss_ready_o, 1'b1);
        chk1("stray_rd_req", rd_req_o, 1'b0);
        chk1("stray_refill", refill_valid_o, 1'b0);
        chk32("stray_miss_cnt", miss_cnt_o, 32'd0);

        // Saturation of the miss counter
        force dut.u_miss_cnt.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_miss_cnt.r_count;
        chk32("sat_pre", miss_cnt_o, 32'hFFFF_FFFF);
        ram_en = 1'b1;
        drive_miss(32'h128, 1'b0, 32'h0, 128'd0);
        sb.push_back(exp_t'{32'h120, 32'hCCCC2222, line_a});
        tick(); miss_req_i = 1'b0;
        chk32("sat_post", miss_cnt_o, 32'hFFFF_FFFF);
        tick(); tick(); tick();
        chk1("sat_ready", miss_ready_o, 1'b1);
        chk32("sat_hold", miss_cnt_o, 32'hFFFF_FFFF);
        tick(); tick();

        chk32("sb_drain", 32'(sb.size()), 32'd0);
        chk32("err_pulse_count", 32'(err_pulses), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
